// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
// States, default byte width and the cyclic index helper used by the arbiter.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    S_ARB    = 3'd0,
    S_ACCEPT = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DONE   = 3'd4
  } arb_state_e;

  localparam logic [2:0] ST_ARB    = S_ARB;
  localparam logic [2:0] ST_ACCEPT = S_ACCEPT;
  localparam logic [2:0] ST_LOAD   = S_LOAD;
  localparam logic [2:0] ST_START  = S_START;
  localparam logic [2:0] ST_DONE   = S_DONE;

  // Next index modulo n; wraps explicitly so non power-of-two counts stay in range.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status signals of the UART transmit arbiter.
// Handshake: a byte moves on a clock edge where req_valid[i] && req_ready[i]; valid must hold with stable data until then.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         uart_txd;
  logic                          uart_txv;
  logic                          uart_active;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic                          timeout_err;
  logic [2:0]                    dbg_state;
  logic [ID_W-1:0]               dbg_rr_ptr;

  modport master (
    output req_valid, req_data, req_last, uart_active,
    input  req_ready, uart_txd, uart_txv, grant_id, busy, timeout_err,
           dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_active,
    output req_ready, uart_txd, uart_txv, grant_id, busy, timeout_err,
           dbg_state, dbg_rr_ptr
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after i_ptr, searching cyclically.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_cand = w_sum[IW-1:0];
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte streams, locked per packet.
// Define UART_ARB_TIMEOUT_EN to force release of a packet whose owner stalls TIMEOUT cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int TIMEOUT    = 1024,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  logic [2:0]            r_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant;
  logic [DATA_WIDTH-1:0] r_txd;
  logic                  r_last;
  logic                  r_timeout_err;

  logic                  w_found;
  logic [ID_W-1:0]       w_pick;
  logic                  w_owner_valid;
  logic                  w_hs;
  logic                  w_force_release;
  logic [ID_W-1:0]       w_next_ptr;

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_rr_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_owner_valid = bus.req_valid[r_grant];
  assign w_hs          = (r_state == ST_ACCEPT) && w_owner_valid;
  assign w_next_ptr    = ID_W'(next_idx(int'(r_grant), NUM_REQ));

  always_comb begin
    bus.req_ready = '0;
    if (r_state == ST_ACCEPT) bus.req_ready[r_grant] = w_owner_valid;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] r_to_cnt;

  // Counts owner idle cycles inside a locked packet; anything else restarts it.
  assign w_force_release = (r_state == ST_ACCEPT) && !w_owner_valid &&
                           (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_ACCEPT) && !w_owner_valid && !w_force_release) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  assign w_force_release = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_ARB;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_txd         <= '0;
      r_last        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_ARB: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (w_hs) begin
            r_txd   <= bus.req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
            r_last  <= bus.req_last[r_grant];
            r_state <= ST_LOAD;
          end else if (w_force_release) begin
            r_timeout_err <= 1'b1;
            r_last        <= 1'b0;
            r_rr_ptr      <= w_next_ptr;
            r_state       <= ST_ARB;
          end
        end
        ST_LOAD: r_state <= ST_START;
        ST_START: begin
          if (bus.uart_active) r_state <= ST_DONE;
        end
        ST_DONE: begin
          // Lock is held across bytes until the flagged last byte has left the line.
          if (!bus.uart_active) begin
            if (r_last) begin
              r_rr_ptr <= w_next_ptr;
              r_state  <= ST_ARB;
            end else begin
              r_state <= ST_ACCEPT;
            end
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign bus.uart_txd    = r_txd;
  assign bus.uart_txv    = (r_state == ST_LOAD);
  assign bus.grant_id    = r_grant;
  assign bus.busy        = (r_state != ST_ARB);
  assign bus.timeout_err = r_timeout_err;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_rr_ptr  = r_rr_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: uart_tx model, requester drivers and an ordered byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;
  localparam int FRAME   = 10;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int OUT_W   = DW + 1 + NUM_REQ + 1 + ID_W + 3 + ID_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic          drv_valid [NUM_REQ];
  logic [DW-1:0] drv_data  [NUM_REQ];
  logic          drv_last  [NUM_REQ];

  always_comb begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]         = drv_valid[i];
      bus.req_data[i*DW +: DW] = drv_data[i];
      bus.req_last[i]          = drv_last[i];
    end
  end

  // uart_tx model: active rises the edge after txv and stays high FRAME cycles.
  int act_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.uart_active <= 1'b0;
      act_cnt         <= 0;
    end else if (bus.uart_txv) begin
      bus.uart_active <= 1'b1;
      act_cnt         <= FRAME;
    end else if (act_cnt > 0) begin
      act_cnt <= act_cnt - 1;
      if (act_cnt == 1) bus.uart_active <= 1'b0;
    end
  end

  logic [ID_W+DW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int to_pulses = 0;
  logic prev_txv = 1'b0;

  function automatic logic [OUT_W-1:0] out_vec();
    return {bus.uart_txd, bus.uart_txv, bus.req_ready, bus.busy, bus.grant_id,
            bus.dbg_state, bus.dbg_rr_ptr, bus.timeout_err};
  endfunction

  task automatic run_monitor();
    logic [ID_W+DW-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_txv = 1'b0;
      end else begin
        if (bus.uart_txv) begin
          n_total++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got id=%0d data=%h, required no transmission", bus.grant_id, bus.uart_txd);
          end else begin
            exp_v = exp_q.pop_front();
            if ({bus.grant_id, bus.uart_txd} !== exp_v) begin
              n_bad++;
              $display("FAIL sb_byte: got id=%0d data=%h, required id=%0d data=%h",
                       bus.grant_id, bus.uart_txd, exp_v[ID_W+DW-1:DW], exp_v[DW-1:0]);
            end
          end
          n_total++;
          if (prev_txv !== 1'b0) begin
            n_bad++;
            $display("FAIL double_txv: got txv on consecutive cycles, required single-cycle pulse");
          end
          n_total++;
          if (bus.uart_active !== 1'b0) begin
            n_bad++;
            $display("FAIL txv_while_active: got active=%b at txv, required 0", bus.uart_active);
          end
        end
        if (bus.timeout_err === 1'b1) to_pulses++;
        prev_txv = bus.uart_txv;
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = '0;
      drv_last[i]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] b);
    exp_q.push_back({ID_W'(id), b});
  endtask

  task automatic send_pkt(input int id, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                          input logic [DW-1:0] b2, input int len, input logic last_en);
    logic ok;
    for (int i = 0; i < len; i++) begin
      drv_data[id]  = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      drv_last[id]  = last_en && (i == len - 1);
      drv_valid[id] = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 600 && !ok; c++) begin
        #1;
        if (bus.req_ready[id] === 1'b1) ok = 1'b1;
        else @(negedge clk);
      end
      if (!ok) begin
        n_total++;
        n_bad++;
        $display("FAIL hs_timeout: got no ready for req %0d, required handshake", id);
        drv_valid[id] = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    drv_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (bus.dbg_state == ST_ARB && !bus.uart_active) ok = 1'b1;
    end
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL idle_timeout: got state=%0d, required ARB", bus.dbg_state);
    end
    n_total++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending bytes, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++;
    if (out_vec() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, required 0", out_vec());
    end
  endtask

  task automatic test_single_req();
    push_exp(2, 8'h41);
    push_exp(2, 8'h42);
    push_exp(2, 8'h43);
    send_pkt(2, 8'h41, 8'h42, 8'h43, 3, 1'b1);
    wait_idle();
    n_total++;
    if (bus.dbg_rr_ptr !== ID_W'(3)) begin
      n_bad++;
      $display("FAIL single_rr_ptr: got %0d, required 3", bus.dbg_rr_ptr);
    end
    n_total++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy: got %b, required 0", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    push_exp(0, 8'hA0);
    push_exp(1, 8'hB1);
    push_exp(0, 8'hA2);
    fork
      begin
        send_pkt(0, 8'hA0, 8'h00, 8'h00, 1, 1'b1);
        send_pkt(0, 8'hA2, 8'h00, 8'h00, 1, 1'b1);
      end
      send_pkt(1, 8'hB1, 8'h00, 8'h00, 1, 1'b1);
    join
    wait_idle();
    n_total++;
    if (bus.dbg_rr_ptr !== ID_W'(1)) begin
      n_bad++;
      $display("FAIL rr_ptr_after: got %0d, required 1", bus.dbg_rr_ptr);
    end
  endtask

  task automatic test_lock();
    logic seen;
    push_exp(1, 8'hC1);
    push_exp(1, 8'hC2);
    push_exp(1, 8'hC3);
    push_exp(0, 8'hD0);
    fork
      send_pkt(1, 8'hC1, 8'hC2, 8'hC3, 3, 1'b1);
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (bus.dbg_state == ST_START) break;
        end
        send_pkt(0, 8'hD0, 8'h00, 8'h00, 1, 1'b1);
      end
      begin
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
          @(negedge clk);
          #1;
          if (bus.req_ready[0] === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (exp_q.size() !== 1) begin
          n_bad++;
          $display("FAIL lock_ready_early: got ready[0] with %0d bytes pending, required 1", exp_q.size());
        end
      end
    join
    wait_idle();
  endtask

  task automatic test_timing();
    push_exp(3, 8'h3C);
    drv_data[3]  = 8'h3C;
    drv_last[3]  = 1'b1;
    drv_valid[3] = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bus.req_ready[3], bus.uart_txv, bus.grant_id} !== {1'b1, 1'b0, ID_W'(3)}) begin
      n_bad++;
      $display("FAIL timing_c1: got ready=%b txv=%b grant=%0d, required ready=1 txv=0 grant=3",
               bus.req_ready[3], bus.uart_txv, bus.grant_id);
    end
    @(negedge clk);
    drv_valid[3] = 1'b0;
    n_total++;
    if ({bus.uart_txv, bus.req_ready[3]} !== 2'b10) begin
      n_bad++;
      $display("FAIL timing_c2: got txv=%b ready=%b, required txv=1 ready=0", bus.uart_txv, bus.req_ready[3]);
    end
    @(negedge clk);
    n_total++;
    if ({bus.uart_txv, bus.uart_active} !== 2'b01) begin
      n_bad++;
      $display("FAIL timing_c3: got txv=%b active=%b, required txv=0 active=1", bus.uart_txv, bus.uart_active);
    end
    wait_idle();
    n_total++;
    if (bus.dbg_rr_ptr !== ID_W'(0)) begin
      n_bad++;
      $display("FAIL rr_wrap: got %0d, required 0", bus.dbg_rr_ptr);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    push_exp(1, 8'h5A);
    drv_data[1]  = 8'h5A;
    drv_last[1]  = 1'b1;
    drv_valid[1] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (bus.dbg_state == ST_START) ok = 1'b1;
    end
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL reach_start: got state=%0d, required START", bus.dbg_state);
    end
    drv_valid[1] = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if (out_vec() !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %h, required 0", out_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    push_exp(2, 8'h77);
    send_pkt(2, 8'h77, 8'h00, 8'h00, 1, 1'b1);
    wait_idle();
    n_total++;
    if (bus.dbg_rr_ptr !== ID_W'(3)) begin
      n_bad++;
      $display("FAIL post_reset_rr: got %0d, required 3", bus.dbg_rr_ptr);
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int before;
    do_reset();
    before = to_pulses;
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    send_pkt(0, 8'h11, 8'h00, 8'h00, 1, 1'b0);
    send_pkt(1, 8'h22, 8'h00, 8'h00, 1, 1'b1);
    wait_idle();
    n_total++;
    if (to_pulses - before !== 1) begin
      n_bad++;
      $display("FAIL timeout_pulses: got %0d, required 1", to_pulses - before);
    end
  endtask
`endif

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single_req();
    test_round_robin();
    test_lock();
    test_timing();
    test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`else
    n_total++;
    if (to_pulses !== 0) begin
      n_bad++;
      $display("FAIL timeout_tied: got %0d pulses, required 0", to_pulses);
    end
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
